multicycle_cpu: RTL

// - Parametrised multi-cycle successor to the single-cycle 16-bit core: same 16-bit ISA encoding
//   (opcode[15:12], rs[11:9], rt[8:6], rd[5:3], imm6[5:0], imm12[11:0]), configurable datapath width.
// - An FSM sequences fetch, decode, execute, memory and writeback.
// - Instruction and data memories are external, behind req/ack handshakes, so wait states are tolerated.
// - Sits at the top of the processor subsystem in place of the single-cycle core.

---
 rtl/multicycle_cpu.sv | 240 ++++++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_cpu.sv
// multicycle_cpu: multi-cycle core for the 16-bit ISA, instruction/data memories behind req/ack handshakes.
// Optional ILLEGAL_TRAP_EN: opcodes B..E halt the core with trap=1 instead of executing as NOP.
module multicycle_cpu #(
   parameter int              DATA_W   = 16,
   parameter int              PC_W     = 16,
   parameter logic [PC_W-1:0] RESET_PC = {PC_W{1'b0}}
) (
   input  logic              clock,
   input  logic              clr,
   output logic              imem_req,
   output logic [PC_W-1:0]   imem_addr,
   input  logic [15:0]       imem_rdata,
   input  logic              imem_ack,
   output logic              dmem_req,
   output logic              dmem_we,
   output logic [DATA_W-1:0] dmem_addr,
   output logic [DATA_W-1:0] dmem_wdata,
   input  logic [DATA_W-1:0] dmem_rdata,
   input  logic              dmem_ack,
   output logic [PC_W-1:0]   pc,
   output logic              halted,
   output logic              trap
);

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4,
      S_HALTED = 3'd5
   } state_t;

   localparam logic [3:0] OP_ADD  = 4'h0;
   localparam logic [3:0] OP_SUB  = 4'h1;
   localparam logic [3:0] OP_AND  = 4'h2;
   localparam logic [3:0] OP_OR   = 4'h3;
   localparam logic [3:0] OP_SLT  = 4'h4;
   localparam logic [3:0] OP_ADDI = 4'h5;
   localparam logic [3:0] OP_LW   = 4'h6;
   localparam logic [3:0] OP_SW   = 4'h7;
   localparam logic [3:0] OP_BEQ  = 4'h8;
   localparam logic [3:0] OP_BNE  = 4'h9;
   localparam logic [3:0] OP_J    = 4'hA;
   localparam logic [3:0] OP_HALT = 4'hF;

   localparam logic [PC_W-1:0] PC_ONE = {{(PC_W-1){1'b0}}, 1'b1};

   state_t            state_r, next_s;
   logic [PC_W-1:0]   pc_r, pc_next_s, pc_inc_s, br6_s, br12_s;
   logic [15:0]       ir_r;
   logic [DATA_W-1:0] rf_r [8];
   logic [DATA_W-1:0] a_r, b_r, res_r, alu_s, imm6_s;
   logic [DATA_W-1:0] dmem_addr_r, dmem_wdata_r;
   logic              imem_req_r, dmem_req_r, dmem_we_r, halted_r;
   logic              imem_done_s, dmem_done_s, slt_s;
   logic [3:0]        opcode_s;
   logic [2:0]        rs_s, rt_s, rd_s, wdest_s;

   assign opcode_s = ir_r[15:12];
   assign rs_s     = ir_r[11:9];
   assign rt_s     = ir_r[8:6];
   assign rd_s     = ir_r[5:3];
   assign imm6_s   = {{(DATA_W-6){ir_r[5]}}, ir_r[5:0]};
   assign br6_s    = {{(PC_W-6){ir_r[5]}}, ir_r[5:0]};
   assign br12_s   = {{(PC_W-12){ir_r[11]}}, ir_r[11:0]};
   assign pc_inc_s = pc_r + PC_ONE;
   assign slt_s    = $signed(a_r) < $signed(b_r);

   // An ack only counts while our own request is up; stale acks are dropped here.
   assign imem_done_s = (state_r == S_FETCH) && imem_req_r && imem_ack;
   assign dmem_done_s = (state_r == S_MEM) && dmem_req_r && dmem_ack;

   // ALU: arithmetic/logic result, also the effective address for loads and stores
   always_comb begin
      alu_s = {DATA_W{1'b0}};
      case (opcode_s)
         OP_ADD:                 alu_s = a_r + b_r;
         OP_SUB:                 alu_s = a_r - b_r;
         OP_AND:                 alu_s = a_r & b_r;
         OP_OR:                  alu_s = a_r | b_r;
         OP_SLT:                 alu_s = {{(DATA_W-1){1'b0}}, slt_s};
         OP_ADDI, OP_LW, OP_SW:  alu_s = a_r + imm6_s;
         default:                alu_s = {DATA_W{1'b0}};
      endcase
   end

   // Writeback destination: I-type results land in rt, R-type in rd
   always_comb begin
      wdest_s = rd_s;
      if ((opcode_s == OP_ADDI) || (opcode_s == OP_LW)) begin
         wdest_s = rt_s;
      end else begin
         wdest_s = rd_s;
      end
   end

   // Next-state and next-PC logic
   always_comb begin
      next_s    = state_r;
      pc_next_s = pc_r;
      case (state_r)
         S_FETCH: begin
            if (imem_done_s) next_s = S_DECODE;
            else             next_s = S_FETCH;
         end
         S_DECODE: next_s = S_EXEC;
         S_EXEC: begin
            case (opcode_s)
               OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT, OP_ADDI: next_s = S_WB;
               OP_LW, OP_SW: next_s = S_MEM;
               OP_BEQ: begin
                  next_s    = S_FETCH;
                  pc_next_s = (a_r == b_r) ? (pc_inc_s + br6_s) : pc_inc_s;
               end
               OP_BNE: begin
                  next_s    = S_FETCH;
                  pc_next_s = (a_r != b_r) ? (pc_inc_s + br6_s) : pc_inc_s;
               end
               OP_J: begin
                  next_s    = S_FETCH;
                  pc_next_s = pc_inc_s + br12_s;
               end
               OP_HALT: next_s = S_HALTED;
               default: begin
`ifdef ILLEGAL_TRAP_EN
                  next_s = S_HALTED;
`else
                  next_s    = S_FETCH;
                  pc_next_s = pc_inc_s;
`endif
               end
            endcase
         end
         S_MEM: begin
            if (dmem_done_s) begin
               if (opcode_s == OP_LW) begin
                  next_s = S_WB;
               end else begin
                  next_s    = S_FETCH;
                  pc_next_s = pc_inc_s;
               end
            end else begin
               next_s = S_MEM;
            end
         end
         S_WB: begin
            next_s    = S_FETCH;
            pc_next_s = pc_inc_s;
         end
         S_HALTED: next_s = S_HALTED;
         default:  next_s = S_FETCH;
      endcase
   end

   // Control registers: state, PC, IR and the registered bus handshake outputs
   always_ff @(posedge clock or negedge clr) begin
      if (!clr) begin
         state_r      <= S_FETCH;
         pc_r         <= RESET_PC;
         ir_r         <= 16'h0000;
         imem_req_r   <= 1'b0;
         dmem_req_r   <= 1'b0;
         dmem_we_r    <= 1'b0;
         dmem_addr_r  <= {DATA_W{1'b0}};
         dmem_wdata_r <= {DATA_W{1'b0}};
         halted_r     <= 1'b0;
      end else begin
         state_r    <= next_s;
         pc_r       <= pc_next_s;
         imem_req_r <= (next_s == S_FETCH);
         dmem_req_r <= (next_s == S_MEM);
         halted_r   <= (next_s == S_HALTED);
         if (imem_done_s) begin
            ir_r <= imem_rdata;
         end
         // Address, data and direction are captured once and held for the whole access
         if ((state_r == S_EXEC) && (next_s == S_MEM)) begin
            dmem_addr_r  <= alu_s;
            dmem_wdata_r <= b_r;
            dmem_we_r    <= (opcode_s == OP_SW);
         end else if (next_s != S_MEM) begin
            dmem_we_r <= 1'b0;
         end
      end
   end

   // Datapath registers: register file, operand latches and result latch
   always_ff @(posedge clock or negedge clr) begin
      if (!clr) begin
         for (int i = 0; i < 8; i++) begin
            rf_r[i] <= {DATA_W{1'b0}};
         end
         a_r   <= {DATA_W{1'b0}};
         b_r   <= {DATA_W{1'b0}};
         res_r <= {DATA_W{1'b0}};
      end else begin
         if (state_r == S_DECODE) begin
            a_r <= rf_r[rs_s];
            b_r <= rf_r[rt_s];
         end
         if (state_r == S_EXEC) begin
            res_r <= alu_s;
         end else if (dmem_done_s) begin
            res_r <= dmem_rdata;
         end
         // R0 is never written, so it always reads as zero
         if ((state_r == S_WB) && (wdest_s != 3'd0)) begin
            rf_r[wdest_s] <= res_r;
         end
      end
   end

`ifdef ILLEGAL_TRAP_EN
   logic trap_r;

   // Trap flag: the only way into HALTED other than HALT is an illegal opcode
   always_ff @(posedge clock or negedge clr) begin
      if (!clr) begin
         trap_r <= 1'b0;
      end else begin
         trap_r <= (next_s == S_HALTED) && (opcode_s != OP_HALT);
      end
   end

   assign trap = trap_r;
`else
   assign trap = 1'b0;
`endif

   assign imem_req   = imem_req_r;
   assign imem_addr  = pc_r;
   assign dmem_req   = dmem_req_r;
   assign dmem_we    = dmem_we_r;
   assign dmem_addr  = dmem_addr_r;
   assign dmem_wdata = dmem_wdata_r;
   assign pc         = pc_r;
   assign halted     = halted_r;

endmodule
